// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO queue: default parameters, pointer width
// and occupancy compare helpers for the almost flags.
package fifo_pkg;

  localparam int DEF_ADDR_BITS = 2;
  localparam int DEF_WORD_BITS = 4;
  localparam int DEF_AE_LEVEL  = 1;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int ptr_bits(input int addr_bits);
    return addr_bits + 1;
  endfunction

  function automatic int def_af_level(input int addr_bits);
    return (1 << addr_bits) - 1;
  endfunction

  function automatic logic occ_at_least(input int occ, input int level);
    return occ >= level;
  endfunction

  function automatic logic occ_at_most(input int occ, input int level);
    return occ <= level;
  endfunction

endpackage

// File: rtl/fifo_queue_if.sv
// Producer/consumer handshake bundle for fifo_queue. The master side drives
// requests and write data; the slave side (the queue) drives head data and status.
interface fifo_queue_if
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
);

  logic                 wr;
  logic                 rd;
  logic [WORD_BITS-1:0] wr_data;
  logic [WORD_BITS-1:0] rd_data;
  logic                 empty;
  logic                 full;
  logic [ADDR_BITS:0]   count;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr, rd, wr_data,
    input  rd_data, empty, full, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, rd, wr_data,
    output rd_data, empty, full, count, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x WORD_BITS storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_queue.sv
// Synchronous first-word-fall-through FIFO: pointers, status decode and
// optional sticky error flags (enabled with the QUEUE_ERR_EN macro).
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int AF_LEVEL  = def_af_level(ADDR_BITS),
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  fifo_queue_if.slave  q_if
);

  localparam int PTR_W = ptr_bits(ADDR_BITS);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     count_w;
  logic                 empty_w;
  logic                 full_w;
  logic                 push_ok;
  logic                 pop_ok;
  logic [WORD_BITS-1:0] head_w;

  // Status decodes only from registered pointers, never from wr/rd.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
                   (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);

  // A pop frees the head slot this cycle, so a push is accepted even when full.
  assign push_ok = q_if.wr & (~full_w | q_if.rd);
  assign pop_ok  = q_if.rd & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_regfile #(
    .ADDR_BITS (ADDR_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_regfile (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q[ADDR_BITS-1:0]),
    .wdata_i (q_if.wr_data),
    .raddr_i (rd_ptr_q[ADDR_BITS-1:0]),
    .rdata_o (head_w)
  );

  assign q_if.rd_data      = empty_w ? '0 : head_w;
  assign q_if.empty        = empty_w;
  assign q_if.full         = full_w;
  assign q_if.count        = count_w;
  assign q_if.almost_full  = occ_at_least(int'(count_w), AF_LEVEL);
  assign q_if.almost_empty = occ_at_most(int'(count_w), AE_LEVEL);

`ifdef QUEUE_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (q_if.wr & ~push_ok);
    underflow_d = underflow_q | (q_if.rd & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign q_if.overflow  = overflow_q;
  assign q_if.underflow = underflow_q;
`else
  assign q_if.overflow  = 1'b0;
  assign q_if.underflow = 1'b0;
`endif

endmodule
